// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-path constants and the {pc, instr} queue entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: power-of-two FIFO of fetch entries with single-cycle flush
module fetch_queue import riscv_pkg::*; #(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  fetch_entry_t mem [QUEUE_DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  assign full = cnt == (PW+1)'(QUEUE_DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC + fetch queue to decode; FETCH_MISALIGN_TRAP_EN adds a sticky misaligned-redirect fault
module fetch_unit import riscv_pkg::*; #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault
`endif
);
  logic [31:0] pc, target;
  logic push, pop, full, empty, fault;
  fetch_entry_t head;
`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fetch_fault <= 1'b0;
    else if (redirect_valid && |redirect_pc[1:0]) fetch_fault <= 1'b1;
  assign fault = fetch_fault;
  assign target = redirect_pc;
`else
  assign fault = 1'b0;
  assign target = redirect_pc & 32'hFFFF_FFFC;
`endif
  assign imem_addr = pc;
  assign dec_valid = !empty && !redirect_valid && !fault;
  assign pop = dec_valid && dec_ready;
  assign push = !redirect_valid && !fault && (!full || pop);
  assign dec_pc = head.pc;
  assign dec_instr = head.instr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_VECTOR;
    else pc <= redirect_valid ? target : push ? pc + PC_STEP : pc;
  fetch_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_queue (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .wdata('{pc: pc, instr: imem_rdata}),
    .full(full),
    .empty(empty),
    .head(head)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a queue-based reference model
module tb_fetch_unit;
  import riscv_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 1;
  logic [31:0] imem_addr, imem_rdata, redirect_pc = 0, dec_pc, dec_instr;
  logic redirect_valid = 0, dec_ready = 0, dec_valid;
  logic nop_mode = 1;
  int total = 0, bad = 0;
  fetch_entry_t q[$];
  logic [31:0] acc[$];
  logic [31:0] m_pc;
  logic m_fault = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_fault;
`endif

  fetch_unit #(.RESET_VECTOR(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return nop_mode ? NOP_INSTR : (a ^ 32'hA5A5_0000);
  endfunction
  assign imem_rdata = instr_of(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; spans the next rising edge.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic ev, pop, can_push;
    redirect_valid = rv;
    redirect_pc = rpc;
    dec_ready = rdy;
    #1;
    ev = q.size() != 0 && !rv && !m_fault;
    chk("imem_addr", imem_addr, m_pc);
    chk("dec_valid", {31'b0, dec_valid}, {31'b0, ev});
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
`endif
    if (ev) begin
      chk("dec_pc", dec_pc, q[0].pc);
      chk("dec_instr", dec_instr, q[0].instr);
    end
    pop = ev && rdy;
    can_push = !rv && !m_fault && (q.size() < DEPTH || pop);
    if (pop) begin
      acc.push_back(q[0].pc);
      void'(q.pop_front());
    end
    if (rv) begin
      q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc = rpc;
      if (rpc[1:0] != 2'b00) m_fault = 1;
`else
      m_pc = {rpc[31:2], 2'b00};
`endif
    end else if (can_push) begin
      q.push_back('{pc: m_pc, instr: instr_of(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    #1;
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    q.delete();
    m_pc = 32'h0;
    m_fault = 0;
    #1 rst_n = 1;
  endtask

  initial begin
    logic rv;
    logic [31:0] rpc;
    @(negedge clk);
    pulse_reset();
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_instr", dec_instr, 32'h0);
    // back-to-back fetch from reset with NOPs
    acc.delete();
    repeat (4) step(0, 0, 1);
    chk("seq_n", acc.size(), 3);
    for (int i = 0; i < 3; i++) chk("seq_pc", acc[i], 32'(i * 4));
    // stall on full queue, then drain
    pulse_reset();
    acc.delete();
    repeat (5) step(0, 0, 0);
    #1;
    chk("stall_pc", imem_addr, 32'h8);
    chk("stall_head", dec_pc, 32'h0);
    repeat (4) step(0, 0, 1);
    for (int i = 0; i < 3; i++) chk("drain_pc", acc[i], 32'(i * 4));
    // redirect flushes wrong-path entries
    step(1, 32'h10, 0);
    repeat (2) step(0, 0, 0);
    acc.delete();
    step(1, 32'h100, 1);
    repeat (2) step(0, 0, 1);
    chk("redir_first", acc[0], 32'h100);
    // PC wrap
    acc.delete();
    step(1, 32'hFFFF_FFFC, 1);
    repeat (3) step(0, 0, 1);
    chk("wrap0", acc[0], 32'hFFFF_FFFC);
    chk("wrap1", acc[1], 32'h0);
    // async reset with full queue
    repeat (3) step(0, 0, 0);
    #1;
    chk("full_valid", {31'b0, dec_valid}, 32'h1);
    pulse_reset();
    // random traffic
    nop_mode = 0;
    for (int i = 0; i < 400; i++) begin
      rv = $urandom_range(0, 7) == 0;
      rpc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc[1:0] = 2'b00;
`endif
      step(rv, rpc, $urandom_range(0, 3) != 0);
    end
    // misaligned redirect
    step(1, 32'h102, 1);
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign_pc", imem_addr, 32'h102);
    chk("misalign_fault", {31'b0, fetch_fault}, 32'h1);
`else
    chk("misalign_pc", imem_addr, 32'h100);
`endif
    repeat (4) step(0, 0, 1);
    pulse_reset();
    repeat (3) step(0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of InstructionMem.
- Owns the program counter and drives it to the instruction memory every cycle. The memory's read is combinational, so the instruction returns in the same cycle.
- Buffers {pc, instruction} pairs in a small queue and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute; a redirect flushes all wrong-path entries.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- QUEUE_DEPTH, 2, fetch queue entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  current PC to InstructionMem (pc input).
- imem_rdata  in  32  instruction returned combinationally for imem_addr.
- redirect_valid  in  1  taken branch/jump from execute this cycle.
- redirect_pc  in  32  target PC for the redirect.
- dec_valid  out  1  head queue entry valid for decode.
- dec_ready  in  1  decode accepts the head entry.
- dec_pc  out  32  PC of the head entry.
- dec_instr  out  32  instruction of the head entry.
- fetch_fault  out  1  only with FETCH_MISALIGN_TRAP_EN; sticky misaligned-redirect flag.

Behaviour:
- Reset (async, rst_n=0):
  - pc = RESET_VECTOR.
  - Queue empty: count = 0, read/write pointers = 0, storage = 0.
  - dec_valid = 0, dec_pc = 0, dec_instr = 0, fetch_fault = 0.
  - imem_addr = RESET_VECTOR.
- imem_addr = pc, combinationally.
- pop = dec_valid && dec_ready.
- push = !redirect_valid && (count < QUEUE_DEPTH || pop).
- Push writes {pc, imem_rdata} at the write pointer and sets pc <= pc + 4.
- When push = 0 and there is no redirect, pc holds (stall on full queue).
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Pop advances the read pointer.
- count update: +1 on push only, -1 on pop only, unchanged on both.
- Simultaneous push and pop while full is legal; count stays QUEUE_DEPTH.
- Pointers wrap modulo QUEUE_DEPTH.
- dec_valid = (count != 0) && !redirect_valid. It is forced low in a redirect cycle, so no wrong-path entry is consumed.
- dec_pc / dec_instr show the head entry whenever count != 0; otherwise they are don't-care (the bench checks them only when dec_valid = 1).
- Redirect (redirect_valid = 1), taking priority over push and pop:
  - count <= 0 and pointers <= 0 (full flush).
  - pc <= redirect_pc.
  - Nothing is enqueued that cycle.
- First instruction after a redirect: dec_valid rises 1 cycle after the redirect (pc loaded at edge N, entry enqueued at edge N+1, dec_valid high after N+1).
- Fetch-to-decode latency: 1 cycle (pc presented in cycle N, entry visible on dec_* in cycle N+1).
- Steady-state throughput: 1 instruction/cycle while dec_ready = 1.
- Redirect on consecutive cycles: the last one wins; each flushes.
- rst_n asserted mid-operation: all state returns to reset values immediately (asynchronous); no partial entries survive.
- Without the macro, redirect_pc[1:0] is ignored: pc <= {redirect_pc[31:2], 2'b00}.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_fault = 1 (sticky until reset).
  - Flush occurs as normal; pc loads the unmodified target.
  - While fetch_fault = 1, push is inhibited and dec_valid stays 0.
- Undefined:
  - fetch_fault port absent.
  - Low two bits of redirect_pc are cleared as above; no trap.

Decomposition:
- Shared package riscv_pkg:
  - XLEN = 32, INSTR_W = 32, PC_STEP = 4.
  - NOP_INSTR = 32'h0000_0013 (ADDI x0,x0,0).
  - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
- Sub-module fetch_queue:
  - Parameterised QUEUE_DEPTH FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - fetch_unit keeps the PC register, push/redirect control and fault logic.

Test Plan:
- Reset release, dec_ready = 1, imem returns 32'h0000_0013 → imem_addr 0, 4, 8 on successive cycles; dec_valid rises 1 cycle after reset release; dec_pc 0, 4, 8 in order.
- dec_ready = 0 for 5 cycles from reset → count reaches 2; pc holds at 8; dec_pc = 0. Raising dec_ready → entries 0, 4, 8 delivered back-to-back with no gap or duplicate.
- Queue holding pc 0x10/0x14, redirect_valid with redirect_pc = 0x100 → dec_valid = 0 that cycle; next dec_pc = 0x100; 0x10/0x14 never accepted.
- Redirect with redirect_pc = 0xFFFF_FFFC → fetched PCs 0xFFFF_FFFC then 0x0000_0000 (wrap).
- rst_n pulsed low between clock edges with the queue full → dec_valid = 0 immediately, without waiting for a clock edge; imem_addr = RESET_VECTOR.
- redirect_pc = 0x102:
  - Without the macro → pc = 0x100.
  - With FETCH_MISALIGN_TRAP_EN → fetch_fault = 1, dec_valid held 0 until reset.
